// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard stall/flush controller:
// register-index width, the x0 index and the memory-wait state encoding.
package hazard_stall_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    // True when an operand that is actually read matches the producing register.
    function automatic logic operand_hit(
        input logic                 use_rs,
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] rd
    );
        return use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    // Count register: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (inc && (q != ALL_ONES)) begin
            q <= q + W'(1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use stalls,
// taken-branch flushes and a bounded data-memory wait in the M stage.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_D,
    input  logic [REG_IDX_W-1:0] rs2_D,
    input  logic                 use_rs1_D,
    input  logic                 use_rs2_D,
    input  logic [REG_IDX_W-1:0] rd_E,
    input  logic                 mem_read_E,
    input  logic                 pc_src_E,
    input  logic                 mem_req_M,
    input  logic                 mem_ack_M,
    input  logic                 cnt_clr,
    output logic                 stall_F,
    output logic                 stall_D,
    output logic                 stall_E,
    output logic                 stall_M,
    output logic                 flush_D,
    output logic                 flush_E,
    output logic                 bubble_W,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          state_r;
    state_e          state_nxt_s;
    logic [TO_W-1:0] to_cnt_r;
    logic            timeout_s;
    logic            mem_wait_s;
    logic            load_use_s;

    assign timeout_s = (state_r == MEM_WAIT) && !mem_ack_M && (to_cnt_r == TO_LAST);

    // The first miss cycle already stalls, and the ack cycle never does.
    assign mem_wait_s = ((state_r == IDLE) && mem_req_M && !mem_ack_M) ||
                        ((state_r == MEM_WAIT) && !mem_ack_M && !timeout_s);

    // Loads into x0 never create a dependency.
    assign load_use_s = mem_read_E && (rd_E != REG_X0) &&
                        (operand_hit(use_rs1_D, rs1_D, rd_E) ||
                         operand_hit(use_rs2_D, rs2_D, rd_E));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic for the memory-wait FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_req_M && !mem_ack_M) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_M || timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Timeout counter: zero on entry to MEM_WAIT, one step per waiting cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == MEM_WAIT) && (state_nxt_s == MEM_WAIT)) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Error pulse lands in the cycle after the aborted wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= timeout_s;
        end
    end

    // Output decode: memory wait beats branch flush beats load-use stall.
    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        stall_E  = 1'b0;
        stall_M  = 1'b0;
        flush_D  = 1'b0;
        flush_E  = 1'b0;
        bubble_W = 1'b0;
        if (rst) begin
            stall_F = 1'b0;
        end else if (mem_wait_s) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            stall_E  = 1'b1;
            stall_M  = 1'b1;
            bubble_W = 1'b1;
        end else if (pc_src_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (load_use_s) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end else begin
            stall_F = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (stall_F),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (flush_D),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    rs1_D = 5'd0, rs2_D = 5'd0, rd_E = 5'd0;
    logic          use_rs1_D = 1'b0, use_rs2_D = 1'b0, mem_read_E = 1'b0;
    logic          pc_src_E = 1'b0, mem_req_M = 1'b0, mem_ack_M = 1'b0, cnt_clr = 1'b0;
    logic          stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
        .rd_E(rd_E), .mem_read_E(mem_read_E), .pc_src_E(pc_src_E),
        .mem_req_M(mem_req_M), .mem_ack_M(mem_ack_M), .cnt_clr(cnt_clr),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .bubble_W(bubble_W), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100010;
    localparam logic [6:0] O_BR   = 7'b0000110;
    localparam logic [6:0] O_MW   = 7'b1111001;

    typedef struct {
        string         name;
        logic [6:0]    o;
        logic          err;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: compare DUT outputs against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [6:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W};
            n_checks += 4;
            if (act !== e.o) begin
                n_fail++;
                $display("FAIL %s outputs: got %b expected %b", e.name, act, e.o);
            end
            if (mem_err !== e.err) begin
                n_fail++;
                $display("FAIL %s mem_err: got %b expected %b", e.name, mem_err, e.err);
            end
            if (stall_cnt !== e.sc) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.sc);
            end
            if (flush_cnt !== e.fc) begin
                n_fail++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.fc);
            end
        end
    end

    // One cycle of stimulus plus its expected response.
    task automatic cyc(
        input string n, input logic r,
        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
        input logic [4:0] rde, input logic mre, input logic pcs,
        input logic req, input logic ack, input logic clr,
        input logic [6:0] eo, input logic eerr, input int esc, input int efc
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; rs1_D = rs1; use_rs1_D = u1; rs2_D = rs2; use_rs2_D = u2;
        rd_E = rde; mem_read_E = mre; pc_src_E = pcs;
        mem_req_M = req; mem_ack_M = ack; cnt_clr = clr;
        e.name = n; e.o = eo; e.err = eerr; e.sc = CW'(esc); e.fc = CW'(efc);
        sb.push_back(e);
    endtask

    initial begin
        #1 rst = 1'b1;
        //  name        rst rs1  u1 rs2  u2 rdE  mr pc req ack clr  exp     err sc fc
        cyc("reset",    1, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 0, 0);
        cyc("idle",     0, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 0, 0);
        cyc("lu_rs1",   0, 5'd5,1,5'd0,0,5'd5,1,0, 0,0,0, O_LU,   0, 0, 0);
        cyc("lu_after", 0, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 1, 0);
        cyc("x0_load",  0, 5'd0,1,5'd0,0,5'd0,1,0, 0,0,0, O_NONE, 0, 1, 0);
        cyc("rs2_unused",0,5'd3,1,5'd5,0,5'd5,1,0, 0,0,0, O_NONE, 0, 1, 0);
        cyc("lu_rs2",   0, 5'd3,1,5'd5,1,5'd5,1,0, 0,0,0, O_LU,   0, 1, 0);
        cyc("br_lu",    0, 5'd5,1,5'd0,0,5'd5,1,1, 0,0,0, O_BR,   0, 2, 0);
        cyc("br_after", 0, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 2, 1);
        cyc("mw_miss",  0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_MW,   0, 2, 1);
        cyc("mw_wait1", 0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_MW,   0, 3, 1);
        cyc("mw_wait2_br",0,5'd5,1,5'd0,0,5'd5,1,1,1,0,0, O_MW,   0, 4, 1);
        cyc("mw_ack",   0, 5'd0,0,5'd0,0,5'd0,0,0, 1,1,0, O_NONE, 0, 5, 1);
        cyc("mw_idle",  0, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 5, 1);
        cyc("to_miss",  0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_MW,   0, 5, 1);
        cyc("to_w0",    0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_MW,   0, 6, 1);
        cyc("to_w1",    0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_MW,   0, 7, 1);
        cyc("to_w2",    0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_MW,   0, 8, 1);
        cyc("to_abort", 0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_NONE, 0, 9, 1);
        cyc("to_err",   0, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 1, 9, 1);
        cyc("to_err_end",0,5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 9, 1);
        cyc("clr_lu",   0, 5'd5,1,5'd0,0,5'd5,1,0, 0,0,1, O_LU,   0, 9, 1);
        cyc("clr_done", 0, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc("sat_fill", 0, 5'd5,1,5'd0,0,5'd5,1,0, 0,0,0, O_LU, 0, (i < 15) ? i : 15, 0);
        end
        cyc("sat_hold", 0, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 15, 0);
        cyc("rst_miss", 0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_MW,   0, 15, 0);
        cyc("rst_wait", 0, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_MW,   0, 15, 0);
        cyc("rst_mid",  1, 5'd0,0,5'd0,0,5'd0,0,0, 1,0,0, O_NONE, 0, 0, 0);
        cyc("rst_idle", 0, 5'd0,0,5'd0,0,5'd0,0,0, 0,0,0, O_NONE, 0, 0, 0);

        for (int k = 0; k < 5 && sb.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Stall/flush controller for the 5-stage RV32I pipeline. It drives the freeze and bubble side of hazard resolution; forwarding is handled in a separate block. It covers three cases: load-use stalls, taken-branch/jump flushes, and a variable-latency data-memory wait in the M stage. It also keeps saturating performance counters for stall cycles and flush events.

Parameters:
MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before the controller aborts the wait and raises mem_err
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
rs1_D  input  5  rs1 field of the instruction in Decode
rs2_D  input  5  rs2 field of the instruction in Decode
use_rs1_D  input  1  Decode instruction reads rs1
use_rs2_D  input  1  Decode instruction reads rs2
rd_E  input  5  destination register of the instruction in Execute
mem_read_E  input  1  Execute instruction is a load
pc_src_E  input  1  branch taken or jump resolved in Execute
mem_req_M  input  1  M stage is issuing a data-memory access this cycle
mem_ack_M  input  1  data memory completes the access this cycle
cnt_clr  input  1  synchronous clear of both counters
stall_F  output  1  hold the PC
stall_D  output  1  hold the IF/ID register
stall_E  output  1  hold the ID/EX register
stall_M  output  1  hold the EX/MEM register
flush_D  output  1  zero the IF/ID register
flush_E  output  1  zero the ID/EX register
bubble_W  output  1  write a bubble (reg_write=0) into MEM/WB
mem_err  output  1  one-cycle pulse on memory timeout
stall_cnt  output  CNT_W  number of cycles in which stall_F was high
flush_cnt  output  CNT_W  number of cycles in which flush_D was high

Behaviour:
- Reset is async on rst rising and applies while rst is high:
  - state = IDLE, timeout counter = 0, mem_err = 0, stall_cnt = 0, flush_cnt = 0.
  - All stall, flush and bubble outputs are forced to 0 while rst is high.
- FSM states: IDLE, MEM_WAIT.
  - IDLE -> MEM_WAIT when mem_req_M=1 and mem_ack_M=0.
  - MEM_WAIT -> IDLE when mem_ack_M=1.
  - MEM_WAIT -> IDLE on timeout, i.e. when the timeout counter reaches MEM_TIMEOUT-1 without an ack.
  - The timeout counter is cleared on entry to MEM_WAIT and increments once per MEM_WAIT cycle.
- mem_wait is combinational: (IDLE and mem_req_M and !mem_ack_M) or (MEM_WAIT and !mem_ack_M and not at timeout). This gives zero-latency stalls, so the first miss cycle already stalls.
- load_use = mem_read_E and rd_E != 0 and ((use_rs1_D and rs1_D == rd_E) or (use_rs2_D and rs2_D == rd_E)).
- Output priority, all combinational:
  1. mem_wait: stall_F = stall_D = stall_E = stall_M = 1 and bubble_W = 1; flush_D = flush_E = 0. Flushes are not lost: pc_src_E is held by the frozen ID/EX register and reasserts once the pipeline advances.
  2. Otherwise, if pc_src_E: flush_D = flush_E = 1; all stalls = 0. The load-use condition is ignored because the Decode instruction is being discarded.
  3. Otherwise, if load_use: stall_F = stall_D = 1 and flush_E = 1. This inserts exactly one bubble.
  4. Otherwise: all outputs 0.
- The ack cycle (mem_ack_M=1) never stalls, in either state.
- mem_err is registered. It goes high for exactly one cycle, in the cycle after the timeout transition.
- Counters:
  - Both update on the clk edge and saturate at all-ones; they never wrap.
  - cnt_clr takes priority over an increment in the same cycle.
  - An increment happens when the corresponding output was high in that cycle.

Decomposition:
- Shared pipeline package holds: state encoding constants (IDLE = 1'b0, MEM_WAIT = 1'b1), the register-index width (5), and the x0 constant.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) is instantiated twice.

Test Plan:
- Load-use: lw x5 in Execute (rd_E=5, mem_read_E=1); add in Decode with rs1_D=5, use_rs1_D=1 -> stall_F = stall_D = flush_E = 1 for one cycle; stall_cnt increments by 1.
- x0 and unused operands:
  - rd_E=0 with rs1_D=0 -> no stall.
  - rs2_D=5 with use_rs2_D=0 -> no stall.
- Branch plus load-use in the same cycle: pc_src_E=1 and load_use=1 -> flush_D = flush_E = 1, stall_F = 0; flush_cnt increments by 1.
- Memory wait: mem_req_M=1, ack arrives after 3 cycles -> all stalls and bubble_W are high for exactly 3 cycles, low on the ack cycle; state is back in IDLE.
- Timeout: mem_req_M held with no ack, MEM_TIMEOUT=4 -> stalls for 4 cycles, mem_err pulses once, state returns to IDLE.
- Saturation and reset:
  - Preload stall_cnt near all-ones (CNT_W=4, 15 stall cycles), add one more stall -> stall_cnt stays at 15.
  - Assert rst mid-MEM_WAIT -> all outputs 0 immediately; counters 0.
